prog_mem_loader: RTL and testbench

- Byte-stream writer that fills the CPU program ROM (16-bit words) or the data RAM through the memory write port.
- Sits between a boot/debug byte source (UART/SPI receiver) and the memory's write/read port.
- Assembles little-endian byte pairs into words and writes them to consecutive addresses.
- Validates the whole image with a trailing 8-bit checksum byte.

---
 rtl/prog_mem_loader_if.sv | 24 ++
 rtl/prog_mem_loader.sv | 152 +++++++++++++++
 tb/tb_prog_mem_loader.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_mem_loader_if.sv
// Byte-stream and memory-port bundle for prog_mem_loader.
// master = loader side, slave = byte source plus memory side.
interface prog_mem_loader_if #(
  parameter int ADDR_BUS_WIDTH = 14
);
  logic                      s_valid;
  logic                      s_ready;
  logic [7:0]                s_data;
  logic [ADDR_BUS_WIDTH-1:0] mem_a;
  logic [15:0]               mem_d;
  logic [15:0]               mem_q;
  logic                      mem_we;
  logic                      mem_re;

  modport master (
    input  s_valid, s_data, mem_q,
    output s_ready, mem_a, mem_d, mem_we, mem_re
  );

  modport slave (
    output s_valid, s_data, mem_q,
    input  s_ready, mem_a, mem_d, mem_we, mem_re
  );
endinterface

// File: rtl/prog_mem_loader.sv
// Assembles little-endian byte pairs into 16-bit words, writes them to consecutive
// addresses and validates the image with a trailing checksum byte.
// Define PROG_MEM_LOADER_VERIFY_EN to add a read-back compare after each write.
module prog_mem_loader #(
  parameter int ADDR_BUS_WIDTH = 14,
  parameter int CNT_WIDTH      = 15
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic [ADDR_BUS_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]      word_count,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  prog_mem_loader_if.master         bus
);
  typedef enum logic [3:0] {
    S_IDLE, S_LO, S_HI, S_WR, S_RD, S_CMP, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t                    state_q, state_d;
  logic [ADDR_BUS_WIDTH-1:0] base_q, base_d;
  logic [CNT_WIDTH-1:0]      count_q, count_d;
  logic [CNT_WIDTH-1:0]      index_q, index_d;
  logic [7:0]                sum_q, sum_d;
  logic [7:0]                lo_q, lo_d;
  logic [ADDR_BUS_WIDTH-1:0] mem_a_q, mem_a_d;
  logic [15:0]               mem_d_q, mem_d_d;
  logic                      error_q, error_d;

  logic       s_ready, mem_we, mem_re, xfer;
  logic [7:0] sum_nxt;

  assign xfer    = bus.s_valid & s_ready;
  assign sum_nxt = sum_q + bus.s_data;

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    count_d = count_q;
    index_d = index_q;
    sum_d   = sum_q;
    lo_d    = lo_q;
    mem_a_d = mem_a_q;
    mem_d_d = mem_d_q;
    error_d = error_q;
    s_ready = 1'b0;
    mem_we  = 1'b0;
    mem_re  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        base_d  = base_addr;
        count_d = word_count;
        index_d = '0;
        sum_d   = '0;
        error_d = 1'b0;
        state_d = (word_count == '0) ? S_CSUM : S_LO;
      end
      S_LO: begin
        busy    = 1'b1;
        s_ready = 1'b1;
        if (xfer) begin
          lo_d    = bus.s_data;
          sum_d   = sum_nxt;
          state_d = S_HI;
        end
      end
      S_HI: begin
        busy    = 1'b1;
        s_ready = 1'b1;
        // Address and data are registered here so they are stable through WR/RD.
        if (xfer) begin
          mem_d_d = {bus.s_data, lo_q};
          mem_a_d = base_q + index_q[ADDR_BUS_WIDTH-1:0];
          sum_d   = sum_nxt;
          state_d = S_WR;
        end
      end
      S_WR: begin
        busy    = 1'b1;
        mem_we  = 1'b1;
        index_d = index_q + CNT_WIDTH'(1);
`ifdef PROG_MEM_LOADER_VERIFY_EN
        state_d = S_RD;
`else
        state_d = (index_d == count_q) ? S_CSUM : S_LO;
`endif
      end
`ifdef PROG_MEM_LOADER_VERIFY_EN
      S_RD: begin
        busy    = 1'b1;
        mem_re  = 1'b1;
        state_d = S_CMP;
      end
      S_CMP: begin
        busy = 1'b1;
        if (bus.mem_q != mem_d_q) state_d = S_ERR;
        else                      state_d = (index_q == count_q) ? S_CSUM : S_LO;
      end
`endif
      S_CSUM: begin
        busy    = 1'b1;
        s_ready = 1'b1;
        if (xfer) state_d = (sum_nxt == 8'h00) ? S_DONE : S_ERR;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort overrides any in-flight decision; a write strobed this cycle still lands.
    if (abort && busy) state_d = S_ERR;
    if (state_d == S_ERR) error_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      count_q <= '0;
      index_q <= '0;
      sum_q   <= '0;
      lo_q    <= '0;
      mem_a_q <= '0;
      mem_d_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      count_q <= count_d;
      index_q <= index_d;
      sum_q   <= sum_d;
      lo_q    <= lo_d;
      mem_a_q <= mem_a_d;
      mem_d_q <= mem_d_d;
      error_q <= error_d;
    end
  end

  assign bus.s_ready = s_ready;
  assign bus.mem_we  = mem_we;
  assign bus.mem_re  = mem_re;
  assign bus.mem_a   = mem_a_q;
  assign bus.mem_d   = mem_d_q;
  assign error       = error_q;
endmodule

// File: tb/tb_prog_mem_loader.sv
// Directed scoreboard bench for prog_mem_loader: expected writes are queued when
// the stream is driven and popped as mem_we strobes appear.
module tb_prog_mem_loader;
  localparam int AW = 14;
  localparam int CW = 15;
`ifdef PROG_MEM_LOADER_VERIFY_EN
  localparam int WORD_CYC = 5;
`else
  localparam int WORD_CYC = 3;
`endif

  typedef struct {
    logic [AW-1:0] a;
    logic [15:0]   d;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [CW-1:0] word_count = '0;
  logic          busy, done, error;

  prog_mem_loader_if #(.ADDR_BUS_WIDTH(AW)) mif ();

  prog_mem_loader #(.ADDR_BUS_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .base_addr(base_addr), .word_count(word_count),
    .busy(busy), .done(done), .error(error), .bus(mif.master)
  );

  always #5 clk = ~clk;

  // Memory model with registered read and an optional stuck-at-0 bit 3.
  logic [15:0] mem [0:(1<<AW)-1];
  logic        stuck = 1'b0;
  always @(posedge clk) begin
    if (mif.mem_we) mem[mif.mem_a] <= mif.mem_d & (stuck ? 16'hFFF7 : 16'hFFFF);
    mif.mem_q <= mem[mif.mem_a];
  end

  int  n_assert = 0, n_fail = 0;
  int  we_cnt = 0, done_cnt = 0, re_cnt = 0;
  int  cyc = 0, last_we_cyc = 0, last_gap = 0;
  bit  have_we = 0, prev_we = 0;
  wr_t exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (rst_n) begin
    if (mif.mem_re) begin
      re_cnt++;
      chk("re_follows_we", 32'(prev_we), 32'd1);
    end
    if (mif.mem_we) begin
      wr_t e;
      we_cnt++;
      if (have_we) last_gap = cyc - last_we_cyc;
      last_we_cyc = cyc;
      have_we = 1;
      chk("wr_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(mif.mem_a), 32'(e.a));
        chk("wr_data", 32'(mif.mem_d), 32'(e.d));
      end
`ifndef PROG_MEM_LOADER_VERIFY_EN
      chk("no_re", 32'(mif.mem_re), 32'd0);
`endif
    end
    prev_we = mif.mem_we;
    if (done) done_cnt++;
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic do_start(input logic [AW-1:0] b, input logic [CW-1:0] n);
    start = 1'b1; base_addr = b; word_count = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok = 0;
    mif.s_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    mif.s_valid = 1'b1; mif.s_data = b;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = mif.s_ready;
      @(posedge clk); #1;
    end
    if (!ok) chk("timeout_ready", 32'(mif.s_ready), 32'd1);
    mif.s_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = !busy;
    end
    if (!ok) chk("timeout_idle", 32'(busy), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic push_wr(input logic [AW-1:0] a, input logic [15:0] d);
    wr_t e;
    e.a = a; e.d = d;
    exp_q.push_back(e);
  endtask

  initial begin
    int w0, d0;
    logic [7:0] basic[5];
    basic[0] = 8'h34; basic[1] = 8'h12; basic[2] = 8'h78; basic[3] = 8'h56; basic[4] = 8'hEC;
    mif.s_valid = 1'b0; mif.s_data = '0;

    #1;
    chk("rst_s_ready", 32'(mif.s_ready), 0);
    chk("rst_we_re",   32'({mif.mem_we, mif.mem_re}), 0);
    chk("rst_flags",   32'({busy, done, error}), 0);
    chk("rst_mem_a",   32'(mif.mem_a), 0);
    chk("rst_mem_d",   32'(mif.mem_d), 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic load
    push_wr(14'h0100, 16'h1234); push_wr(14'h0101, 16'h5678);
    w0 = we_cnt; d0 = done_cnt;
    do_start(14'h0100, 15'd2);
    chk("busy_after_start", 32'(busy), 1);
    foreach (basic[i]) send_byte(basic[i], 0);
    wait_idle();
    chk("basic_we", 32'(we_cnt - w0), 2);
    chk("basic_gap", 32'(last_gap), 32'(WORD_CYC));
    chk("basic_done", 32'(done_cnt - d0), 1);
    chk("basic_err", 32'(error), 0);

    // Bad checksum
    push_wr(14'h0100, 16'h1234); push_wr(14'h0101, 16'h5678);
    w0 = we_cnt; d0 = done_cnt;
    do_start(14'h0100, 15'd2);
    for (int i = 0; i < 4; i++) send_byte(basic[i], 0);
    send_byte(8'hED, 0);
    wait_idle();
    chk("badck_we", 32'(we_cnt - w0), 2);
    chk("badck_done", 32'(done_cnt - d0), 0);
    chk("badck_err_busy", 32'({error, busy}), 32'b10);

    // Empty image; its start clears the sticky error
    w0 = we_cnt; d0 = done_cnt;
    do_start(14'h0000, 15'd0);
    chk("start_clears_err", 32'({error, busy}), 32'b01);
    send_byte(8'h00, 0);
    wait_idle();
    chk("empty_we", 32'(we_cnt - w0), 0);
    chk("empty_done", 32'(done_cnt - d0), 1);

    // Address wrap: 11+22+33+44 = AA, checksum 56
    push_wr(14'h3FFF, 16'h2211); push_wr(14'h0000, 16'h4433);
    w0 = we_cnt; d0 = done_cnt;
    do_start(14'h3FFF, 15'd2);
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
    send_byte(8'h56, 0);
    wait_idle();
    chk("wrap_we", 32'(we_cnt - w0), 2);
    chk("wrap_done", 32'(done_cnt - d0), 1);

    // Random gaps plus a start while busy (must be ignored)
    push_wr(14'h0100, 16'h1234); push_wr(14'h0101, 16'h5678);
    w0 = we_cnt; d0 = done_cnt;
    do_start(14'h0100, 15'd2);
    send_byte(basic[0], $urandom_range(0, 5));
    do_start(14'h0300, 15'd7);
    for (int i = 1; i < 5; i++) send_byte(basic[i], $urandom_range(0, 5));
    wait_idle();
    chk("gaps_we", 32'(we_cnt - w0), 2);
    chk("gaps_done", 32'(done_cnt - d0), 1);
    chk("gaps_err", 32'(error), 0);

    // Abort while waiting for the high byte of word 1
    push_wr(14'h0200, 16'h55AA);
    w0 = we_cnt; d0 = done_cnt;
    do_start(14'h0200, 15'd4);
    send_byte(8'hAA, 0); send_byte(8'h55, 0); send_byte(8'h01, 0);
    chk("abort_in_hi", 32'(mif.s_ready), 1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    wait_idle();
    chk("abort_we", 32'(we_cnt - w0), 1);
    chk("abort_done", 32'(done_cnt - d0), 0);
    chk("abort_err", 32'(error), 1);

    // Reset during the write cycle of word 0
    do_start(14'h0123, 15'd4);
    send_byte(8'h11, 0); send_byte(8'h22, 0);
    chk("pre_rst_we", 32'(mif.mem_we), 1);
    chk("pre_rst_a", 32'(mif.mem_a), 32'h0123);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_flags", 32'({busy, done, error, mif.s_ready, mif.mem_we, mif.mem_re}), 0);
    chk("mid_rst_bus", 32'({mif.mem_a, mif.mem_d}), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

`ifdef PROG_MEM_LOADER_VERIFY_EN
    // Stuck bit 3: read-back mismatch aborts without consuming the checksum
    begin
      int r0;
      bit seen = 0;
      stuck = 1'b1;
      push_wr(14'h0040, 16'h0008);
      r0 = re_cnt;
      do_start(14'h0040, 15'd1);
      send_byte(8'h08, 0); send_byte(8'h00, 0);
      mif.s_valid = 1'b1; mif.s_data = 8'hF8;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (mif.s_ready) seen = 1;
      end
      @(posedge clk); #1;
      mif.s_valid = 1'b0;
      stuck = 1'b0;
      chk("vfy_re_pulses", 32'(re_cnt - r0), 1);
      chk("vfy_no_ready", 32'(seen), 0);
      chk("vfy_err_busy", 32'({error, busy}), 32'b10);
    end
`endif

    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
